// File: rtl/ufloat_pkg.sv
// Shared types and constants for the sequential unsigned minifloat adder.
package ufloat_pkg;

    localparam int unsigned DefaultEw = 3;
    localparam int unsigned DefaultMw = 4;
    localparam int unsigned GuardW    = 1;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

endpackage

// File: rtl/ufloat_norm_round.sv
// Normalise a raw mantissa sum, round half-up on the guard bit and saturate on
// exponent overflow.
module ufloat_norm_round
    import ufloat_pkg::*;
#(
    parameter int unsigned EW = DefaultEw,
    parameter int unsigned MW = DefaultMw
) (
    input  logic [MW+1+GuardW:0] i_sum,
    input  logic [EW-1:0]        i_exp,
    output logic [EW+MW-1:0]     o_c,
    output logic                 o_ovf
);

    logic [MW:0]   w_mg;
    logic [MW:0]   w_man_r;
    logic [EW+1:0] w_exp_n;
    logic [EW+1:0] w_exp_r;

    always_comb begin
        // {mantissa, guard} taken one bit higher when the sum carried out
        w_mg    = i_sum[MW+2] ? i_sum[MW+1:1] : i_sum[MW:0];
        w_exp_n = {2'b00, i_exp} + {{(EW+1){1'b0}}, i_sum[MW+2]};
        w_man_r = {1'b0, w_mg[MW:1]} + {{MW{1'b0}}, w_mg[0]};
        w_exp_r = w_exp_n + {{(EW+1){1'b0}}, w_man_r[MW]};
        if (w_exp_r[EW+1:EW] != 2'b00) begin
            o_c   = '1;
            o_ovf = 1'b1;
        end else begin
            o_c   = {w_exp_r[EW-1:0], w_man_r[MW-1:0]};
            o_ovf = 1'b0;
        end
    end

endmodule

// File: rtl/ufloat_add_seq.sv
// Multi-cycle adder for unsigned hidden-one minifloats: align by serial right
// shifts, add, then normalise/round in a single cycle.
module ufloat_add_seq
    import ufloat_pkg::*;
#(
    parameter int unsigned EW = DefaultEw,
    parameter int unsigned MW = DefaultMw
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW-1:0] a,
    input  logic [EW+MW-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW-1:0] c,
    output logic             o
);

    localparam int unsigned MRW = MW + 1 + GuardW;
    localparam int unsigned KW  = $clog2(MW + 3);

    state_e           r_state;
    logic [EW-1:0]    r_ex;
    logic [MRW-1:0]   r_mx;
    logic [MRW-1:0]   r_my;
    logic [KW-1:0]    r_k;
    logic [MRW:0]     r_sum;
    logic [EW+MW-1:0] r_c;
    logic             r_o;

    logic             w_a_is_x;
    logic [EW+MW-1:0] w_x;
    logic [EW+MW-1:0] w_y;
    logic [EW-1:0]    w_diff;
    logic [KW-1:0]    w_k;
    logic [EW+MW-1:0] w_c;
    logic             w_ovf;

    always_comb begin
        w_a_is_x = a[EW+MW-1:MW] >= b[EW+MW-1:MW];
        w_x      = w_a_is_x ? a : b;
        w_y      = w_a_is_x ? b : a;
        w_diff   = w_x[EW+MW-1:MW] - w_y[EW+MW-1:MW];
        // Shifting by MW+2 already clears Y, so larger differences saturate there
        if (32'(w_diff) >= MW + 2) begin
            w_k = KW'(MW + 2);
        end else begin
            w_k = KW'(w_diff);
        end
    end

    ufloat_norm_round #(
        .EW (EW),
        .MW (MW)
    ) u_norm_round (
        .i_sum (r_sum),
        .i_exp (r_ex),
        .o_c   (w_c),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_ex    <= '0;
            r_mx    <= '0;
            r_my    <= '0;
            r_k     <= '0;
            r_sum   <= '0;
            r_c     <= '0;
            r_o     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_ex    <= w_x[EW+MW-1:MW];
                        r_mx    <= {1'b1, w_x[MW-1:0], {GuardW{1'b0}}};
                        r_my    <= {1'b1, w_y[MW-1:0], {GuardW{1'b0}}};
                        r_k     <= w_k;
                        r_state <= (w_k != '0) ? StAlign : StAdd;
                    end
                end
                StAlign: begin
                    r_my <= r_my >> 1;
                    r_k  <= r_k - KW'(1);
                    if (r_k == KW'(1)) begin
                        r_state <= StAdd;
                    end
                end
                StAdd: begin
                    r_sum   <= {1'b0, r_mx} + {1'b0, r_my};
                    r_state <= StNorm;
                end
                StNorm: begin
                    r_c     <= w_c;
                    r_o     <= w_ovf;
                    r_state <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign c         = r_c;
    assign o         = r_o;

endmodule

// File: tb/tb_ufloat_add_seq.sv
// Directed scoreboard bench for ufloat_add_seq with EW=3, MW=4.
module tb_ufloat_add_seq;

    localparam int unsigned EW = 3;
    localparam int unsigned MW = 4;
    localparam int unsigned W  = EW + MW;

    typedef struct {
        logic [W-1:0] c;
        logic         o;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         o;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    ufloat_add_seq #(
        .EW (EW),
        .MW (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .o         (o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] ec, input logic eo, input int el);
        exp_t e;
        int   n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        e.c      = ec;
        e.o      = eo;
        e.lat    = el;
        exp_q.push_back(e);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_c"}, 32'(c), 32'(e.c));
            chk({tag, "_o"}, 32'(o), 32'(e.o));
            chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
        end
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_o", 32'(o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(7'b100_1000, 7'b100_1000, 7'b101_1000, 1'b0, 2);
        recv("eq_exp_carry");
        send(7'b111_1000, 7'b111_1000, 7'b111_1111, 1'b1, 2);
        recv("overflow");
        send(7'b010_0000, 7'b100_0000, 7'b100_0100, 1'b0, 4);
        recv("swapped");
        send(7'b100_0000, 7'b000_1000, 7'b100_0010, 1'b0, 6);
        recv("round_half_up");
        send(7'b100_1110, 7'b000_1000, 7'b101_0000, 1'b0, 6);
        recv("round_carry");
        send(7'b011_0101, 7'b011_0011, 7'b100_0100, 1'b0, 2);
        recv("eq_exp_mixed");

        // Saturated shift count, consumer stalls, busy-time inputs ignored
        out_ready = 1'b0;
        send(7'b111_0000, 7'b000_0001, 7'b111_0000, 1'b0, 8);
        chk("busy_c_kept", 32'(c), 32'(7'b100_0100));
        in_valid = 1'b1;
        a        = 7'b100_1000;
        b        = 7'b100_1000;
        recv("sat_diff");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_c", 32'(c), 32'(7'b111_0000));
            chk("hold_o", 32'(o), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_no_accept", 32'(in_ready), 32'd1);
        chk("handshake_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of alignment
        send(7'b010_0000, 7'b100_0000, 7'b100_0100, 1'b0, 4);
        chk("align_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_c", 32'(c), 32'd0);
        chk("midrst_o", 32'(o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("no_result_after_rst", 32'(seen), 32'd0);
        send(7'b010_0000, 7'b100_0000, 7'b100_0100, 1'b0, 4);
        recv("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ufloat_add_seq.md
UFLOAT_ADD_SEQ -- requirements
Module: ufloat_add_seq

Interface
REQ-001 The block SHALL have parameter EW, default 3: exponent field width in bits.
REQ-002 The block SHALL have parameter MW, default 4: stored mantissa width in bits, with an implied hidden leading 1.
REQ-003 The block SHALL use this number format: unsigned, word = {exp[EW-1:0], man[MW-1:0]}, value = 1.man * 2^exp, with no zero, denormal, sign or bias.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-008 The block SHALL have ports a and b, inputs, EW+MW bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port c, output, EW+MW bits: the sum.
REQ-012 The block SHALL have port o, output, 1 bit: exponent overflow flag, qualified by out_valid.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, ALIGN, ADD, NORM and DONE; in_ready SHALL equal (state==IDLE) and out_valid SHALL equal (state==DONE).
REQ-014 Acceptance SHALL occur on an edge with in_valid && in_ready; on that edge the block SHALL:
- register the operand with the larger exponent as X, the other as Y (if exponents are equal, X=a);
- load mantissa registers as {1, man, guard=0}, MW+2 bits each;
- load shift count k = min(expX-expY, MW+2).
REQ-015 From accept, the next state SHALL be ALIGN if k>0, else ADD.
REQ-016 In ALIGN, each cycle SHALL shift Y's mantissa right by 1 (zero fill) and decrement k; the state SHALL go to ADD when k reaches 0.
REQ-017 A difference of MW+2 or more SHALL zero Y, so the result equals X rounded, i.e. X unchanged.
REQ-018 ADD SHALL form sum = mX + mY, MW+3 bits, register it, and go to NORM.
REQ-019 NORM SHALL normalise, round and check overflow in one cycle, then go to DONE:
- if the sum carries out, shift the sum right 1 (the guard becomes the shifted-out bit) and add 1 to the exponent;
- round half-up: if guard=1, increment the mantissa;
- if the increment overflows the mantissa, set mantissa to 0 and add 1 to the exponent;
- if the exponent exceeds 2^EW-1, saturate c to all ones and set o=1; otherwise set o=0.
REQ-020 Latency from the accept edge to out_valid high SHALL be k+2 cycles; minimum 2, maximum MW+4.
REQ-021 DONE SHALL hold c and o stable until an out_valid && out_ready edge, then go to IDLE.
REQ-022 A new operand pair SHALL NOT be accepted in the same cycle as the result handshake.
REQ-023 in_valid, a and b SHALL be ignored outside IDLE.
REQ-024 c and o SHALL keep their last values in IDLE, ALIGN, ADD and NORM.

Reset
REQ-025 Asserting reset at any time, including mid-operation, SHALL immediately force: state=IDLE, c=0, o=0, out_valid=0, in_ready=1, and all internal registers to 0.
REQ-026 Any in-flight operation SHALL be discarded on reset, with no result emitted.

Structure
REQ-027 Package ufloat_pkg SHALL hold the FSM state enum, default EW/MW values and the guard-width constant (1).
REQ-028 The normalise/round/overflow logic SHALL be one combinational sub-module, ufloat_norm_round, instantiated once in the NORM path.

Verification (EW=3, MW=4; each scenario SHALL be a bench requirement)
REQ-029 a=100_1000, b=100_1000 -> c=101_1000, o=0, latency 2.
REQ-030 a=111_1000, b=111_1000 -> c=111_1111, o=1.
REQ-031 a=010_0000, b=100_0000 (operands swapped) -> c=100_0100, o=0, latency 4.
REQ-032 a=100_0000, b=000_1000 (round half-up) -> c=100_0010; a=100_1110, b=000_1000 (round carry) -> c=101_0000.
REQ-033 a=111_0000, b=000_0001 (difference 7, saturated to 6) -> c=111_0000, latency 8; hold out_ready=0 for 5 cycles -> c stable, in_ready=0.
REQ-034 Assert reset during ALIGN -> out_valid=0 and in_ready=1 immediately; the next operation produces the correct result.
